// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file read side: sizes, the output-stage
// state encoding and the immediate extension helper.
package regfile_pkg;

  localparam int WIDTH   = 16;
  localparam int NREGS   = 16;
  localparam int RADDR_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Widen an 8-bit immediate to a full operand, signed or unsigned.
  function automatic logic [WIDTH-1:0] imm_extend(input logic [7:0] imm8, input logic sext);
    logic [WIDTH-1:0] result;
    if (sext) begin
      result = {{(WIDTH-8){imm8[7]}}, imm8};
    end else begin
      result = {{(WIDTH-8){1'b0}}, imm8};
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_read_unit_operand_select.sv
// One register-file read port: picks r(addr), or the write-back value when that
// register is being written on this same edge.
module operand_select
  import regfile_pkg::*;
(
  input  logic [NREGS*WIDTH-1:0] regs_flat,
  input  logic [WIDTH-1:0]       aluBus,
  input  logic [NREGS-1:0]       regEn,
  input  logic [RADDR_W-1:0]     addr,
  output logic [WIDTH-1:0]       data
);

  always_comb begin
    data = regs_flat[addr*WIDTH +: WIDTH];
    if (regEn[addr]) begin
      data = aluBus;
    end
  end

endmodule

// File: rtl/regfile_read_unit.sv
// Registered operand fetch for the ALU: one-entry valid/ready output stage whose
// held operands keep following register writes while the ALU is stalled.
module regfile_read_unit
  import regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREGS*WIDTH-1:0] regs_flat,
  input  logic [WIDTH-1:0]       aluBus,
  input  logic [NREGS-1:0]       regEn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [RADDR_W-1:0]     req_rdest,
  input  logic [RADDR_W-1:0]     req_rsrc,
  input  logic                   req_use_imm,
  input  logic [7:0]             req_imm,
  input  logic                   req_sext,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  output logic [RADDR_W-1:0]     out_rdest
);

  state_t               state;
  state_t               state_next;
  logic [RADDR_W-1:0]   held_rsrc;
  logic                 held_use_imm;
  logic                 accept;
  logic                 refresh;
  logic [RADDR_W-1:0]   addr_a;
  logic [RADDR_W-1:0]   addr_b;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;

  assign req_ready = (state == EMPTY) | out_ready;
  assign accept    = req_valid & req_ready;
  assign refresh   = (state == FULL) & ~out_ready;
  assign out_valid = (state == FULL);

  // Read ports look at the incoming request on accept, otherwise at what is held.
  assign addr_a = accept ? req_rdest : out_rdest;
  assign addr_b = accept ? req_rsrc  : held_rsrc;

  operand_select u_sel_a (
    .regs_flat (regs_flat),
    .aluBus    (aluBus),
    .regEn     (regEn),
    .addr      (addr_a),
    .data      (sel_a)
  );

  operand_select u_sel_b (
    .regs_flat (regs_flat),
    .aluBus    (aluBus),
    .regEn     (regEn),
    .addr      (addr_b),
    .data      (sel_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = FULL;
      FULL:  if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // A stalled beat re-reads its registers every edge so a late write is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_a         <= '0;
      op_b         <= '0;
      out_rdest    <= '0;
      held_rsrc    <= '0;
      held_use_imm <= 1'b0;
    end else if (accept) begin
      op_a         <= sel_a;
      op_b         <= req_use_imm ? imm_extend(req_imm, req_sext) : sel_b;
      out_rdest    <= req_rdest;
      held_rsrc    <= req_rsrc;
      held_use_imm <= req_use_imm;
    end else if (refresh) begin
      op_a <= sel_a;
      if (!held_use_imm) begin
        op_b <= sel_b;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_unit.sv
// Randomized and directed bench for regfile_read_unit, checked against a
// transaction-level model of the output stage and the register file contents.
module tb_regfile_read_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] regs_flat;
  logic [15:0]  aluBus;
  logic [15:0]  regEn;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_rdest;
  logic [3:0]   req_rsrc;
  logic         req_use_imm;
  logic [7:0]   req_imm;
  logic         req_sext;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  op_a;
  logic [15:0]  op_b;
  logic [3:0]   out_rdest;

  int checkCount = 0;
  int errorCount = 0;

  // Model of the output stage: the beat currently presented to the ALU.
  logic        mValid = 1'b0;
  logic [15:0] mA = '0;
  logic [15:0] mB = '0;
  logic [3:0]  mRdest = '0;
  logic [3:0]  mRsrc = '0;
  logic        mUseImm = 1'b0;

  always #5 clk = ~clk;

  regfile_read_unit dut (
    .clk         (clk),
    .reset       (reset),
    .regs_flat   (regs_flat),
    .aluBus      (aluBus),
    .regEn       (regEn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rdest   (req_rdest),
    .req_rsrc    (req_rsrc),
    .req_use_imm (req_use_imm),
    .req_imm     (req_imm),
    .req_sext    (req_sext),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_rdest   (out_rdest)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Value a read of register k sees at the coming edge.
  function automatic logic [15:0] readReg(input int k);
    if (regEn[k]) return aluBus;
    return regs_flat[k*16 +: 16];
  endfunction

  function automatic logic [15:0] extendImm(input logic [7:0] imm, input logic sext);
    int v;
    v = int'(imm);
    if (sext && v >= 128) v = v + 32'hFF00;
    return v[15:0];
  endfunction

  task automatic setReg(input int k, input logic [15:0] v);
    regs_flat[k*16 +: 16] = v;
  endtask

  task automatic applyStimulus(input logic rv, input logic [3:0] rd, input logic [3:0] rs,
                               input logic ui, input logic [7:0] imm, input logic sx,
                               input logic ordy, input logic [15:0] en, input logic [15:0] bus);
    req_valid   = rv;
    req_rdest   = rd;
    req_rsrc    = rs;
    req_use_imm = ui;
    req_imm     = imm;
    req_sext    = sx;
    out_ready   = ordy;
    regEn       = en;
    aluBus      = bus;
    #1;
    checkOutput("req_ready", 32'(req_ready), 32'(!mValid || out_ready));
  endtask

  // Advance one clock, update the model from the pre-edge inputs, then compare.
  task automatic cycle();
    logic acc;
    @(posedge clk);
    #1;
    if (reset) begin
      mValid = 1'b0; mA = '0; mB = '0; mRdest = '0;
    end else begin
      acc = req_valid && (!mValid || out_ready);
      if (acc) begin
        mA      = readReg(int'(req_rdest));
        mB      = req_use_imm ? extendImm(req_imm, req_sext) : readReg(int'(req_rsrc));
        mRdest  = req_rdest;
        mRsrc   = req_rsrc;
        mUseImm = req_use_imm;
        mValid  = 1'b1;
      end else if (mValid && !out_ready) begin
        mA = readReg(int'(mRdest));
        if (!mUseImm) mB = readReg(int'(mRsrc));
      end else if (mValid) begin
        mValid = 1'b0;
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (regEn[i]) setReg(i, aluBus);
    end
    checkOutput("out_valid", 32'(out_valid), 32'(mValid));
    checkOutput("op_a", 32'(op_a), 32'(mA));
    checkOutput("op_b", 32'(op_b), 32'(mB));
    if (mValid) checkOutput("out_rdest", 32'(out_rdest), 32'(mRdest));
  endtask

  initial begin
    regs_flat = '0;
    for (int i = 0; i < 16; i++) setReg(i, 16'($urandom));
    reset = 1'b1;
    applyStimulus(1'b1, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cycle();
    cycle();
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_op_a", 32'(op_a), 32'd0);
    checkOutput("reset_op_b", 32'(op_b), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("ready_after_reset", 32'(req_ready), 32'd1);
    cycle();
    checkOutput("nothing_accepted", 32'(out_valid), 32'd0);

    setReg(3, 16'h1234);
    setReg(5, 16'h00FF);
    applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 16'h0000);
    cycle();
    checkOutput("fetch_op_a", 32'(op_a), 32'h1234);
    checkOutput("fetch_op_b", 32'(op_b), 32'h00FF);
    checkOutput("fetch_rdest", 32'(out_rdest), 32'd3);

    applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0008, 16'hBEEF);
    cycle();
    checkOutput("bypass_op_a", 32'(op_a), 32'hBEEF);

    applyStimulus(1'b1, 4'd3, 4'd5, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 16'h0000);
    cycle();
    checkOutput("stall_pre_op_b", 32'(op_b), 32'h00FF);
    applyStimulus(1'b1, 4'd7, 4'd8, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0020, 16'h7777);
    checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
    cycle();
    checkOutput("stall_refresh_op_b", 32'(op_b), 32'h7777);
    checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
    checkOutput("stall_rdest_held", 32'(out_rdest), 32'd3);

    applyStimulus(1'b1, 4'd3, 4'd5, 1'b1, 8'h80, 1'b1, 1'b1, 16'h0000, 16'h0000);
    cycle();
    checkOutput("imm_sext", 32'(op_b), 32'hFF80);
    applyStimulus(1'b1, 4'd3, 4'd5, 1'b1, 8'h80, 1'b0, 1'b1, 16'h0000, 16'h0000);
    cycle();
    checkOutput("imm_zext", 32'(op_b), 32'h0080);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0020, 16'h1111);
    cycle();
    checkOutput("imm_stall_kept", 32'(op_b), 32'h0080);

    for (int i = 0; i < 4; i++) begin
      setReg(i + 8, 16'hA000 + 16'(i));
      applyStimulus(1'b1, 4'(i + 8), 4'(i), 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 16'h0000);
      cycle();
      checkOutput("b2b_valid", 32'(out_valid), 32'd1);
      checkOutput("b2b_order", 32'(out_rdest), 32'(i + 8));
      checkOutput("b2b_op_a", 32'(op_a), 32'hA000 + 32'(i));
    end
    applyStimulus(1'b1, 4'd1, 4'd2, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cycle();
    reset = 1'b1;
    cycle();
    checkOutput("reset_while_full", 32'(out_valid), 32'd0);
    reset = 1'b0;

    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      applyStimulus(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0),
                    8'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                    16'($urandom) & 16'($urandom) & 16'($urandom), 16'($urandom));
      cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
